// File: rtl/ex_mem_skid_reg_if.sv
// ----------------------------------------------------------------------------
// ex_mem_skid_reg_if
//   Bundles the EX-side and MEM-side handshake and payload of the EX->MEM
//   skid stage register. The signal names are the stage's port names.
//
//   Modports:
//     slave  : the stage register itself (consumes EX beats, produces MEM beats)
//     master : the environment around it (EX producer + MEM consumer)
//
//   Signals:
//     flush                       synchronous bubble insert
//     in_valid / in_ready         EX-side handshake
//     alu_out_i, rt_data_i, pc_i  EX payload, DATA_W each
//     addr_i                      destination register, ADDR_W
//     mem_to_reg_i                writeback select, M2R_W
//     mem_read_i, mem_write_i,
//     reg_write_i                 EX control bits
//     out_valid / out_ready       MEM-side handshake
//     alu_out_o, rt_data_o, pc_o,
//     addr_o, mem_to_reg_o        registered payload
//     mem_read_o, mem_write_o,
//     reg_write_o                 control bits gated by out_valid
//     occupancy                   number of held beats (0..2)
// ----------------------------------------------------------------------------
interface ex_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int M2R_W  = 2
) ();

  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] pc_i;
  logic [ADDR_W-1:0] addr_i;
  logic [M2R_W-1:0]  mem_to_reg_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              reg_write_i;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] pc_o;
  logic [ADDR_W-1:0] addr_o;
  logic [M2R_W-1:0]  mem_to_reg_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              reg_write_o;
  logic [1:0]        occupancy;

  modport slave (
    input  flush,
    input  in_valid, alu_out_i, rt_data_i, pc_i, addr_i, mem_to_reg_i,
    input  mem_read_i, mem_write_i, reg_write_i,
    output in_ready,
    input  out_ready,
    output out_valid, alu_out_o, rt_data_o, pc_o, addr_o, mem_to_reg_o,
    output mem_read_o, mem_write_o, reg_write_o, occupancy
  );

  modport master (
    output flush,
    output in_valid, alu_out_i, rt_data_i, pc_i, addr_i, mem_to_reg_i,
    output mem_read_i, mem_write_i, reg_write_i,
    input  in_ready,
    output out_ready,
    input  out_valid, alu_out_o, rt_data_o, pc_o, addr_o, mem_to_reg_o,
    input  mem_read_o, mem_write_o, reg_write_o, occupancy
  );

endinterface

// File: rtl/ex_mem_skid_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_skid_reg
//   EX->MEM pipeline stage register with valid/ready handshake on both sides
//   and a 2-entry skid buffer. in_ready is a decode of the registered state,
//   so a MEM-side stall never creates a combinational path back into EX.
//   A synchronous flush empties the stage; write-control outputs are gated
//   by out_valid so a bubble can never write memory or the register file.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears state and all payload
//     bus    ex_mem_skid_reg_if.slave (handshakes, payload, flush, occupancy)
// ----------------------------------------------------------------------------
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int M2R_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ex_mem_skid_reg_if.slave       bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [M2R_W-1:0]  mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } beat_t;

  state_t r_state;
  state_t w_state_nxt;
  beat_t  r_main;
  beat_t  r_skid;
  beat_t  w_in_beat;

  logic   w_main_vld;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_drain;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid;
  logic [1:0] w_occupancy;

  assign w_in_beat = '{
    alu_out:    bus.alu_out_i,
    rt_data:    bus.rt_data_i,
    pc:         bus.pc_i,
    addr:       bus.addr_i,
    mem_to_reg: bus.mem_to_reg_i,
    mem_read:   bus.mem_read_i,
    mem_write:  bus.mem_write_i,
    reg_write:  bus.reg_write_i
  };

  // Main entry is valid in ONE and FULL; the skid entry only in FULL,
  // so both valid bits are pure decodes of the state register.
  assign w_main_vld = (r_state != S_EMPTY);
  // Only the registered state and reset feed in_ready (never out_ready);
  // reset gating keeps every output low while reset is held.
  assign w_in_ready = (r_state != S_FULL) & ~reset;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_drain    = w_main_vld & bus.out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and load-enable decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (bus.flush) begin
      // A concurrent accept is dropped and a concurrent drain completes
      // at the MEM side; nothing is reloaded.
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = S_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (w_drain) begin
            w_state_nxt    = S_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Payload registers: hold their contents unless loaded; flush does not clear them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in_beat;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in_beat;
      end
    end
  end

  always_comb begin
    w_occupancy = 2'd0;
    unique case (r_state)
      S_EMPTY: w_occupancy = 2'd0;
      S_ONE:   w_occupancy = 2'd1;
      S_FULL:  w_occupancy = 2'd2;
      default: w_occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_main_vld;
  assign bus.occupancy    = w_occupancy;
  assign bus.alu_out_o    = r_main.alu_out;
  assign bus.rt_data_o    = r_main.rt_data;
  assign bus.pc_o         = r_main.pc;
  assign bus.addr_o       = r_main.addr;
  // Anything that can steer a write is forced inactive for a bubble.
  assign bus.mem_to_reg_o = w_main_vld ? r_main.mem_to_reg : '0;
  assign bus.mem_read_o   = r_main.mem_read  & w_main_vld;
  assign bus.mem_write_o  = r_main.mem_write & w_main_vld;
  assign bus.reg_write_o  = r_main.reg_write & w_main_vld;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  logic clk;
  logic reset;

  ex_mem_skid_reg_if #(.DATA_W(32), .ADDR_W(5), .M2R_W(2)) b32 ();
  ex_mem_skid_reg_if #(.DATA_W(64), .ADDR_W(6), .M2R_W(2)) b64 ();

  ex_mem_skid_reg #(.DATA_W(32), .ADDR_W(5), .M2R_W(2)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  ex_mem_skid_reg #(.DATA_W(64), .ADDR_W(6), .M2R_W(2)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [1:0]  m2r;
    logic        mr;
    logic        mw;
    logic        rw;
  } beat_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [31:0] alu;
    bit          e_vld;
    bit          e_rdy;
    logic [1:0]  e_occ;
    logic [31:0] e_alu;
    bit          e_rw;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stage is a FIFO of at most two beats; the outputs
  // show the head, and the last head shown persists while the FIFO is empty.
  beat_t q[$];
  beat_t hold;

  vec_t tbl[9];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic beat_t mk(logic [31:0] alu, logic [31:0] pc, logic mr, logic mw,
                               logic rw, logic [1:0] m2r);
    beat_t b;
    b.alu  = alu;
    b.rt   = ~alu;
    b.pc   = pc;
    b.addr = alu[6:2];
    b.m2r  = m2r;
    b.mr   = mr;
    b.mw   = mw;
    b.rw   = rw;
    return b;
  endfunction

  task automatic check_model();
    bit v;
    v = (q.size() > 0);
    chk("out_valid",    b32.out_valid,    v);
    chk("in_ready",     b32.in_ready,     q.size() < 2);
    chk("occupancy",    b32.occupancy,    q.size());
    chk("alu_out_o",    b32.alu_out_o,    hold.alu);
    chk("rt_data_o",    b32.rt_data_o,    hold.rt);
    chk("pc_o",         b32.pc_o,         hold.pc);
    chk("addr_o",       b32.addr_o,       hold.addr);
    chk("mem_to_reg_o", b32.mem_to_reg_o, v ? hold.m2r : 2'b00);
    chk("mem_read_o",   b32.mem_read_o,   hold.mr & v);
    chk("mem_write_o",  b32.mem_write_o,  hold.mw & v);
    chk("reg_write_o",  b32.reg_write_o,  hold.rw & v);
  endtask

  // Drive one cycle on the 32-bit instance, advance the model, then check.
  task automatic step(input beat_t b, input bit iv, input bit ordy, input bit fl);
    bit acc;
    bit drn;
    b32.in_valid     = iv;
    b32.alu_out_i    = b.alu;
    b32.rt_data_i    = b.rt;
    b32.pc_i         = b.pc;
    b32.addr_i       = b.addr;
    b32.mem_to_reg_i = b.m2r;
    b32.mem_read_i   = b.mr;
    b32.mem_write_i  = b.mw;
    b32.reg_write_i  = b.rw;
    b32.out_ready    = ordy;
    b32.flush        = fl;
    acc = iv && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() > 0) hold = q[0];
    #1;
    check_model();
  endtask

  task automatic idle();
    step(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    beat_t b;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 2'd1, 32'h10, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 2'd2, 32'h10, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 1'b0, 2'd2, 32'h10, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 2'd1, 32'h14, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 1'b1, 2'd1, 32'h18, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 2'd0, 32'h18, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 2'd1, 32'h20, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 2'd0, 32'h20, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 2'd0, 32'h20, 1'b0};

    reset = 1'b1;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    b32.alu_out_i = '0; b32.rt_data_i = '0; b32.pc_i = '0; b32.addr_i = '0;
    b32.mem_to_reg_i = '0; b32.mem_read_i = 1'b0; b32.mem_write_i = 1'b0;
    b32.reg_write_i = 1'b0;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.out_ready = 1'b0;
    b64.alu_out_i = '0; b64.rt_data_i = '0; b64.pc_i = '0; b64.addr_i = '0;
    b64.mem_to_reg_i = '0; b64.mem_read_i = 1'b0; b64.mem_write_i = 1'b0;
    b64.reg_write_i = 1'b0;
    hold = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst in_ready",  b32.in_ready,  1'b0);
    chk("rst out_valid", b32.out_valid, 1'b0);
    chk("rst occupancy", b32.occupancy, 2'd0);
    chk("rst alu_out_o", b32.alu_out_o, 32'h0);
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", b32.in_ready, 1'b1);

    // Table-driven sequence: fill, stall, skid drain, reload, flush.
    for (int i = 0; i < 9; i++) begin
      step(mk(tbl[i].alu, tbl[i].alu + 32'h1000, 1'b0, 1'b0, 1'b1, 2'b10),
           tbl[i].iv, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d out_valid", i),   b32.out_valid,   tbl[i].e_vld);
      chk($sformatf("tbl%0d in_ready", i),    b32.in_ready,    tbl[i].e_rdy);
      chk($sformatf("tbl%0d occupancy", i),   b32.occupancy,   tbl[i].e_occ);
      chk($sformatf("tbl%0d alu_out_o", i),   b32.alu_out_o,   tbl[i].e_alu);
      chk($sformatf("tbl%0d reg_write_o", i), b32.reg_write_o, tbl[i].e_rw);
    end

    // Streaming at full throughput.
    for (int i = 0; i < 3; i++) begin
      step(mk(32'h10 + 32'(4 * i), 32'h400, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b1, 1'b0);
      chk("stream alu_out_o", b32.alu_out_o, 32'h10 + 32'(4 * i));
      chk("stream occupancy", b32.occupancy, 2'd1);
      chk("stream in_ready",  b32.in_ready,  1'b1);
      chk("stream reg_write", b32.reg_write_o, 1'b1);
    end
    idle();

    // Stall / skid ordering.
    step(mk(32'h1, 32'h100, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b0, 1'b0);
    step(mk(32'h2, 32'h104, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b0, 1'b0);
    step(mk(32'h3, 32'h108, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b0, 1'b0);
    chk("stall occupancy", b32.occupancy, 2'd2);
    chk("stall in_ready",  b32.in_ready,  1'b0);
    chk("stall pc_o",      b32.pc_o,      32'h100);
    step(mk(32'h3, 32'h108, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b1, 1'b0);
    chk("skid pc_o 2nd",   b32.pc_o,      32'h104);
    chk("skid in_ready",   b32.in_ready,  1'b1);
    step(mk(32'h3, 32'h108, 1'b0, 1'b0, 1'b1, 2'b00), 1'b1, 1'b1, 1'b0);
    chk("skid pc_o 3rd",   b32.pc_o,      32'h108);
    idle();
    chk("skid drained",    b32.out_valid, 1'b0);

    // Flush from FULL with an incoming beat.
    step(mk(32'h30, 32'h200, 1'b0, 1'b1, 1'b0, 2'b00), 1'b1, 1'b0, 1'b0);
    step(mk(32'h34, 32'h204, 1'b0, 1'b1, 1'b0, 2'b00), 1'b1, 1'b0, 1'b0);
    chk("pre-flush mem_write_o", b32.mem_write_o, 1'b1);
    step(mk(32'h38, 32'h208, 1'b0, 1'b1, 1'b0, 2'b00), 1'b1, 1'b0, 1'b1);
    chk("flush out_valid",   b32.out_valid,   1'b0);
    chk("flush mem_write_o", b32.mem_write_o, 1'b0);
    chk("flush occupancy",   b32.occupancy,   2'd0);
    idle();
    idle();
    chk("flushed beat absent", b32.out_valid, 1'b0);

    // Bubble gating after a drain.
    step(mk(32'hABC, 32'h300, 1'b1, 1'b0, 1'b0, 2'b01), 1'b1, 1'b0, 1'b0);
    chk("bubble pre mem_to_reg_o", b32.mem_to_reg_o, 2'b01);
    idle();
    chk("bubble mem_read_o",   b32.mem_read_o,   1'b0);
    chk("bubble mem_to_reg_o", b32.mem_to_reg_o, 2'b00);
    chk("bubble alu_out_o",    b32.alu_out_o,    32'hABC);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      b = mk($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      b.rt   = $urandom;
      b.addr = 5'($urandom);
      step(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset while FULL.
    step(mk(32'h55, 32'h500, 1'b1, 1'b1, 1'b1, 2'b11), 1'b1, 1'b0, 1'b1);
    step(mk(32'h55, 32'h500, 1'b1, 1'b1, 1'b1, 2'b11), 1'b1, 1'b0, 1'b0);
    step(mk(32'h59, 32'h504, 1'b1, 1'b1, 1'b1, 2'b11), 1'b1, 1'b0, 1'b0);
    chk("pre-reset occupancy", b32.occupancy, 2'd2);
    b32.in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst out_valid",    b32.out_valid,    1'b0);
    chk("arst in_ready",     b32.in_ready,     1'b0);
    chk("arst occupancy",    b32.occupancy,    2'd0);
    chk("arst alu_out_o",    b32.alu_out_o,    32'h0);
    chk("arst rt_data_o",    b32.rt_data_o,    32'h0);
    chk("arst pc_o",         b32.pc_o,         32'h0);
    chk("arst addr_o",       b32.addr_o,       5'h0);
    chk("arst mem_to_reg_o", b32.mem_to_reg_o, 2'b00);
    chk("arst mem_read_o",   b32.mem_read_o,   1'b0);
    chk("arst mem_write_o",  b32.mem_write_o,  1'b0);
    chk("arst reg_write_o",  b32.reg_write_o,  1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    q.delete();
    hold = '0;
    chk("arst release in_ready",  b32.in_ready,  1'b1);
    chk("arst release occupancy", b32.occupancy, 2'd0);
    idle();

    // Wide-parameter instance through a stall/drain sequence.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    b64.alu_out_i = 64'hFFFF_FFFF_0000_0001;
    b64.pc_i      = 64'h8000_0000_0000_0010;
    b64.addr_i    = 6'h3F;
    @(posedge clk); #1;
    chk("w64 occ 1",    b64.occupancy, 2'd1);
    chk("w64 alu A",    b64.alu_out_o, 64'hFFFF_FFFF_0000_0001);
    chk("w64 addr A",   b64.addr_o,    6'h3F);
    b64.alu_out_i = 64'h0000_0001_FFFF_FFFE;
    b64.pc_i      = 64'h8000_0000_0000_0014;
    b64.addr_i    = 6'h15;
    @(posedge clk); #1;
    chk("w64 occ 2",      b64.occupancy, 2'd2);
    chk("w64 in_ready",   b64.in_ready,  1'b0);
    chk("w64 alu A held", b64.alu_out_o, 64'hFFFF_FFFF_0000_0001);
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("w64 alu B",  b64.alu_out_o, 64'h0000_0001_FFFF_FFFE);
    chk("w64 addr B", b64.addr_o,    6'h15);
    chk("w64 pc B",   b64.pc_o,      64'h8000_0000_0000_0014);
    @(posedge clk); #1;
    chk("w64 empty",      b64.out_valid, 1'b0);
    chk("w64 alu B held", b64.alu_out_o, 64'h0000_0001_FFFF_FFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised EX→MEM pipeline stage register, the successor to the fixed-width EX/MEM latch.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so a MEM-side stall never forces combinational back-pressure into EX.
- Adds a synchronous flush that inserts a bubble, and gates all write-control outputs on valid.
- Sits between the ALU/branch-resolve logic and the data-memory/writeback path.

Parameters:
- DATA_W, 32, width of the alu_out, rt_data and pc fields.
- ADDR_W, 5, width of the destination register address.
- M2R_W, 2, width of the mem_to_reg select.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous bubble insert; discards all held and incoming beats.
- in_valid  in  1  EX beat present.
- in_ready  out  1  stage can accept a beat; driven from a register.
- alu_out_i  in  DATA_W  ALU result / memory address.
- rt_data_i  in  DATA_W  store data.
- pc_i  in  DATA_W  PC of the instruction (link value).
- addr_i  in  ADDR_W  destination register number.
- mem_to_reg_i  in  M2R_W  writeback select.
- mem_read_i, mem_write_i, reg_write_i  in  1 each  control bits.
- out_valid  out  1  MEM-side beat present.
- out_ready  in  1  MEM stage consumes the beat.
- alu_out_o, rt_data_o, pc_o  out  DATA_W  registered payload.
- addr_o  out  ADDR_W  registered payload.
- mem_to_reg_o  out  M2R_W  registered payload.
- mem_read_o, mem_write_o, reg_write_o  out  1 each  gated control bits.
- occupancy  out  2  number of held beats (0..2).

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry, each with a valid bit.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Derived signals:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - out_valid = main valid.
  - in_ready = (state != FULL); it is a registered state decode and has no combinational path from out_ready.
- Transitions (flush = 0):
  - EMPTY: accept → ONE, payload loads into main.
  - ONE, accept & drain: stay ONE, main reloads with the input.
  - ONE, accept & !drain: → FULL, input loads into skid; main holds.
  - ONE, !accept & drain: → EMPTY.
  - ONE, neither: hold.
  - FULL, drain: → ONE, skid copies into main, skid invalidated. No accept is possible because in_ready = 0.
  - FULL, !drain: hold everything.
- flush = 1 has the highest priority after reset:
  - Next state is EMPTY.
  - A concurrent accept is dropped; upstream treats it as consumed.
  - A concurrent drain still completes at the MEM side, but nothing reloads.
  - Payload data registers are not cleared on flush.
- Output gating:
  - mem_read_o, mem_write_o and reg_write_o equal the main entry's bits AND out_valid.
  - mem_to_reg_o is forced to 0 when out_valid = 0.
  - A bubble therefore can never write memory or the register file.
- Data outputs (alu_out_o, rt_data_o, pc_o, addr_o) hold their last loaded value while invalid.
- Latency: 1 cycle from accept in EMPTY or draining-ONE to out_valid. Full throughput of 1 beat/cycle while out_ready stays high.
- Ordering: strictly FIFO. The skid entry is always older than any new input and is presented before it.
- occupancy = 0, 1 or 2 for EMPTY, ONE or FULL.
- Reset, asynchronous and valid at any time including mid-transfer:
  - State goes to EMPTY.
  - All payload registers and control registers clear to 0.
  - out_valid = 0, occupancy = 0, in_ready = 1 after release.
  - Every output reads 0 during reset.
- Widths: no arithmetic. Fields pass bit-exact at their parameter widths with no truncation or extension.

Test Plan:
- Reset mid-FULL: fill both entries, assert reset → every output 0 immediately, including the payload outputs; after release in_ready = 1, occupancy = 0.
- Streaming: out_ready = 1, in_valid = 1 with alu_out_i = 0x10,0x14,0x18, reg_write_i = 1 → alu_out_o is 0x10,0x14,0x18 on consecutive cycles one cycle later, occupancy stays 1, in_ready stays 1.
- Stall/skid: hold out_ready = 0, send beats pc_i = 0x100 then 0x104 → occupancy 2, in_ready = 0 while a third beat is offered. Release out_ready → 0x100 then 0x104 appear in order, and the third beat is accepted only after in_ready returns to 1.
- Flush: FULL with mem_write = 1 in both entries, pulse flush with in_valid = 1 → next cycle out_valid = 0, mem_write_o = 0, occupancy = 0, and the flushed input never appears.
- Bubble gating: after a beat with mem_read_i = 1 and mem_to_reg_i = 2'b01 drains with no new input → mem_read_o = 0 and mem_to_reg_o = 0 while alu_out_o still holds the old value.
- Parameter sweep: DATA_W = 64, ADDR_W = 6, alu_out_i = 0xFFFF_FFFF_0000_0001, addr_i = 6'h3F → both pass bit-exact through a stall/drain sequence.
